pad_input_conditioner: RTL and testbench

- Consumes the outputs of the padframe Schmitt-trigger input buffers. These are asynchronous, possibly bouncing pad levels.
- Produces clean, clock-synchronous levels, single-cycle edge pulses, and sticky edge flags with a combined interrupt for the core (GPIO / housekeeping).
- One instance per pad bank; each bit is fully independent.

---
 rtl/pad_input_conditioner_if.sv | 28 ++
 rtl/pad_input_conditioner.sv | 131 +++++++++++++
 tb/tb_pad_input_conditioner.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pad_input_conditioner_if.sv
// Bus between a pad bank and its conditioner: raw pad levels and controls in,
// debounced levels, edge pulses, sticky flags and interrupt out.
interface pad_input_conditioner_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] pad_i;
    logic [CNT_W-1:0] debounce_len;
    logic [WIDTH-1:0] en_i;
    logic [WIDTH-1:0] rise_en_i;
    logic [WIDTH-1:0] fall_en_i;
    logic [WIDTH-1:0] flag_clr_i;
    logic [WIDTH-1:0] filt_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic [WIDTH-1:0] flag_o;
    logic             irq_o;

    modport master (
        output pad_i, debounce_len, en_i, rise_en_i, fall_en_i, flag_clr_i,
        input  filt_o, rise_o, fall_o, flag_o, irq_o
    );

    modport slave (
        input  pad_i, debounce_len, en_i, rise_en_i, fall_en_i, flag_clr_i,
        output filt_o, rise_o, fall_o, flag_o, irq_o
    );
endinterface

// File: rtl/pad_input_conditioner.sv
// Pad bank input conditioner: per-bit synchronizer and debounce filter with
// registered edge pulses, plus sticky edge flags and a combined interrupt.

module pad_input_conditioner_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter bit INIT_VAL    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pad,
    input  logic             en,
    input  logic [CNT_W-1:0] neff_m1,
    output logic             filt,
    output logic             rise,
    output logic             fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad};
    end

    // Any sample agreeing with filt restarts the count; >= tolerates
    // debounce_len being lowered while a count is in progress.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (!en || (s == filt_q)) begin
            cnt_d = '0;
        end else if (cnt_q >= neff_m1) begin
            filt_d = s;
            cnt_d  = '0;
            rise_d = s;
            fall_d = ~s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{INIT_VAL}};
            cnt_q  <= '0;
            filt_q <= INIT_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign filt = filt_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

module pad_input_conditioner #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,   // legal 2..4
    parameter int CNT_W       = 8,
    parameter bit INIT_VAL    = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    pad_input_conditioner_if.slave  bus
);
    logic [CNT_W-1:0] neff_m1;
    logic [WIDTH-1:0] filt, rise, fall;
    logic [WIDTH-1:0] flag_q, flag_d;
    logic             irq_q, irq_d;

    // A length of 0 behaves as 1, so the threshold is max(len,1)-1.
    always_comb begin
        neff_m1 = (bus.debounce_len == '0) ? '0 : bus.debounce_len - CNT_W'(1);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        pad_input_conditioner_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .INIT_VAL    (INIT_VAL)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .pad     (bus.pad_i[i]),
            .en      (bus.en_i[i]),
            .neff_m1 (neff_m1),
            .filt    (filt[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    // Sets come from the registered pulses and win over a same-cycle clear.
    always_comb begin
        flag_d = (flag_q & ~bus.flag_clr_i)
               | (rise & bus.rise_en_i)
               | (fall & bus.fall_en_i);
        irq_d  = |flag_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            irq_q  <= irq_d;
        end
    end

    assign bus.filt_o = filt;
    assign bus.rise_o = rise;
    assign bus.fall_o = fall;
    assign bus.flag_o = flag_q;
    assign bus.irq_o  = irq_q;
endmodule

// File: tb/tb_pad_input_conditioner.sv
// Scoreboard bench: two conditioners (INIT_VAL 0 and 1) driven identically and
// compared every cycle against a run-length reference model.
module tb_pad_input_conditioner;
    localparam int W  = 8;
    localparam int SS = 2;
    localparam int CW = 8;

    typedef struct packed {
        logic [1:0][W-1:0] filt;
        logic [1:0][W-1:0] rise;
        logic [1:0][W-1:0] fall;
        logic [1:0][W-1:0] flag;
        logic [1:0]        irq;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [W-1:0]  pad, en, rise_en, fall_en, clr;
    logic [CW-1:0] dlen;
    int checks = 0;
    int errors = 0;
    bit done = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pad_input_conditioner_if #(.WIDTH(W), .CNT_W(CW)) bus0 ();
    pad_input_conditioner_if #(.WIDTH(W), .CNT_W(CW)) bus1 ();

    assign bus0.pad_i = pad;  assign bus1.pad_i = pad;
    assign bus0.debounce_len = dlen;  assign bus1.debounce_len = dlen;
    assign bus0.en_i = en;  assign bus1.en_i = en;
    assign bus0.rise_en_i = rise_en;  assign bus1.rise_en_i = rise_en;
    assign bus0.fall_en_i = fall_en;  assign bus1.fall_en_i = fall_en;
    assign bus0.flag_clr_i = clr;  assign bus1.flag_clr_i = clr;

    pad_input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(CW), .INIT_VAL(1'b0))
        dut0 (.clk(clk), .reset(rst), .bus(bus0));
    pad_input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(CW), .INIT_VAL(1'b1))
        dut1 (.clk(clk), .reset(rst), .bus(bus1));

    // Reference model: pad history per instance, a run length of consecutive
    // enabled samples differing from the filtered level, and the visible outputs.
    logic [W-1:0] m_hist [2][SS];
    logic [W-1:0] m_filt [2];
    logic [W-1:0] m_rise [2];
    logic [W-1:0] m_fall [2];
    logic [W-1:0] m_flag [2];
    int           m_run  [2][W];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < SS; k++) m_hist[d][k] = (d == 1) ? '1 : '0;
            m_filt[d] = (d == 1) ? '1 : '0;
            m_rise[d] = '0;
            m_fall[d] = '0;
            m_flag[d] = '0;
            for (int b = 0; b < W; b++) m_run[d][b] = 0;
        end
    endtask

    task automatic model_step();
        int neff;
        logic s;
        logic [W-1:0] nf, nr, nfa, nflag;
        neff = (dlen == 0) ? 1 : int'(dlen);
        for (int d = 0; d < 2; d++) begin
            nf = m_filt[d]; nr = '0; nfa = '0;
            for (int b = 0; b < W; b++) begin
                s = m_hist[d][SS-1][b];
                if (!en[b] || s == m_filt[d][b]) begin
                    m_run[d][b] = 0;
                end else begin
                    m_run[d][b] = m_run[d][b] + 1;
                    if (m_run[d][b] >= neff) begin
                        nf[b] = s; nr[b] = s; nfa[b] = ~s; m_run[d][b] = 0;
                    end
                end
            end
            nflag = (m_flag[d] & ~clr) | (m_rise[d] & rise_en) | (m_fall[d] & fall_en);
            m_filt[d] = nf; m_rise[d] = nr; m_fall[d] = nfa; m_flag[d] = nflag;
            for (int k = SS-1; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
            m_hist[d][0] = pad;
        end
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic cyc();
        exp_t e;
        if (rst) model_reset(); else model_step();
        for (int d = 0; d < 2; d++) begin
            e.filt[d] = m_filt[d]; e.rise[d] = m_rise[d];
            e.fall[d] = m_fall[d]; e.flag[d] = m_flag[d];
            e.irq[d]  = |m_flag[d];
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int d, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk_outputs(input exp_t e);
        chk("filt_o", 0, bus0.filt_o, e.filt[0]); chk("filt_o", 1, bus1.filt_o, e.filt[1]);
        chk("rise_o", 0, bus0.rise_o, e.rise[0]); chk("rise_o", 1, bus1.rise_o, e.rise[1]);
        chk("fall_o", 0, bus0.fall_o, e.fall[0]); chk("fall_o", 1, bus1.fall_o, e.fall[1]);
        chk("flag_o", 0, bus0.flag_o, e.flag[0]); chk("flag_o", 1, bus1.flag_o, e.flag[1]);
        chk("irq_o", 0, W'(bus0.irq_o), W'(e.irq[0])); chk("irq_o", 1, W'(bus1.irq_o), W'(e.irq[1]));
    endtask

    // Reset asserted between edges must clear everything without a clock.
    task automatic mid_reset();
        exp_t e;
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            e.filt[d] = m_filt[d]; e.rise[d] = '0; e.fall[d] = '0; e.flag[d] = '0; e.irq[d] = 1'b0;
        end
        chk_outputs(e);
        cyc();
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_underflow t=%0t: got empty queue expected an entry", $time);
            end else begin
                e = sb.pop_front();
                chk_outputs(e);
            end
        end
    end

    initial begin : driver
        rst = 1'b1; pad = '0; dlen = 8'd3; en = '1;
        rise_en = '1; fall_en = 8'hFB; clr = '0;
        cyc(); cyc();
        rst = 1'b0;

        pad[0] = 1'b1;                              // basic latency, N=3
        repeat (8) cyc();

        dlen = 8'd4;                                // glitch rejection, N=4
        pad[1] = 1'b1; repeat (3) cyc();
        pad[1] = 1'b0; repeat (6) cyc();
        pad[1] = 1'b1; repeat (8) cyc();

        dlen = 8'd1;                                // flags: rise sets, fall does not
        pad[2] = 1'b1; repeat (4) cyc();
        pad[2] = 1'b0; repeat (4) cyc();
        clr[2] = 1'b1; cyc();
        clr = '0; repeat (2) cyc();

        pad[3] = 1'b1;                              // clear coincides with rise pulse
        for (int i = 0; i < 8; i++) begin
            clr[3] = m_rise[0][3];
            cyc();
        end
        clr = '0; cyc();

        for (int l = 0; l < 2; l++) begin           // len 0 and 1, then per-cycle toggling
            dlen = CW'(l);
            repeat (4) begin pad[5] = ~pad[5]; repeat (3) cyc(); end
            repeat (6) begin pad[6] = ~pad[6]; cyc(); end
            repeat (4) cyc();
        end

        dlen = 8'd10;                               // lower length mid-count
        pad[7] = 1'b1; repeat (7) cyc();
        dlen = 8'd2; repeat (4) cyc();

        en[4] = 1'b0;                               // disabled bit holds
        repeat (8) begin pad[4] = ~pad[4]; repeat (2) cyc(); end
        pad[4] = 1'b1; repeat (4) cyc();
        en = '1; repeat (8) cyc();

        dlen = 8'd6;                                // reset mid-count
        pad = ~pad; repeat (4) cyc();
        mid_reset();
        repeat (10) cyc();

        for (int i = 0; i < 3000; i++) begin
            pad = pad ^ (W'($urandom) & W'($urandom) & W'($urandom));
            clr = W'($urandom) & W'($urandom) & W'($urandom);
            if (i % 64 == 0) dlen = CW'($urandom_range(0, 5));
            if (i % 32 == 0) begin
                rise_en = W'($urandom); fall_en = W'($urandom);
                en = W'($urandom) | W'($urandom);
            end
            if (i % 500 == 499) mid_reset();
            else cyc();
        end
        repeat (3) cyc();

        done = 1'b1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
